// File: rtl/cpu6502_bus_responder.sv
// Bus target for the cpu6502 core: mirrored work RAM, a minimal PPU ctrl/status pair,
// a serial joypad port and the frame-timed vblank NMI generator.
module cpu6502_bus_responder #(
    parameter int RAM_AW       = 11,
    parameter int FRAME_CYCLES = 29781,
    parameter int VBL_START    = 27393,
    parameter int VBL_END      = 0
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    input  logic        we,
    input  logic        re,
    output logic [7:0]  rdata,
    output logic        rvalid,
    input  logic [7:0]  buttons,
    output logic        NMI,
    output logic        vblank
);

    localparam int CW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(FRAME_CYCLES - 1);
    localparam logic [CW-1:0] VS_COUNT   = CW'(VBL_START);
    localparam logic [CW-1:0] VE_COUNT   = CW'(VBL_END);

    logic [7:0]    ram [2**RAM_AW];
    logic [CW-1:0] frame_count;
    logic          nmi_enable;
    logic          strobe;
    logic [7:0]    shift;
    logic [7:0]    read_data;

    logic ram_sel, ppu_sel, ctrl_sel, status_sel, joy_sel;
    logic rd, vbl_set, vbl_clr;

    assign ram_sel    = (addr[15:13] == 3'b000);
    assign ppu_sel    = (addr[15:13] == 3'b001);
    assign ctrl_sel   = ppu_sel && (addr[2:0] == 3'd0);
    assign status_sel = ppu_sel && (addr[2:0] == 3'd2);
    assign joy_sel    = (addr == 16'h4016);

    // A simultaneous write swallows the read, so only a lone re counts as a read.
    assign rd      = re && !we;
    assign vbl_set = (frame_count == VS_COUNT);
    assign vbl_clr = (frame_count == VE_COUNT);

    always_ff @(posedge CLK) begin
        if (!RESET && we && ram_sel)
            ram[addr[RAM_AW-1:0]] <= wdata;
    end

    // Anything not decoded below is open bus and simply re-presents the last rdata.
    always_comb begin
        read_data = rdata;
        if (ram_sel)
            read_data = ram[addr[RAM_AW-1:0]];
        else if (status_sel)
            read_data = vbl_set ? 8'h00 : {vblank, 7'b0};
        else if (joy_sel)
            read_data = {7'b0100000, strobe ? buttons[7] : shift[7]};
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            rdata       <= 8'h00;
            rvalid      <= 1'b0;
            NMI         <= 1'b0;
            vblank      <= 1'b0;
            nmi_enable  <= 1'b0;
            frame_count <= '0;
            shift       <= 8'hFF;
            strobe      <= 1'b0;
        end else begin
            rvalid <= rd;
            if (rd)
                rdata <= read_data;

            frame_count <= (frame_count == LAST_COUNT) ? '0 : frame_count + CW'(1);

            // The frame-timed set beats a status-read clear landing on the same edge.
            if (vbl_set)
                vblank <= 1'b1;
            else if (vbl_clr)
                vblank <= 1'b0;
            else if (rd && status_sel)
                vblank <= 1'b0;

            NMI <= vblank && nmi_enable;

            if (we && ctrl_sel)
                nmi_enable <= wdata[7];
            if (we && joy_sel)
                strobe <= wdata[0];

            // Shifting in ones means reads past the eighth button report 1.
            if (strobe)
                shift <= buttons;
            else if (rd && joy_sel)
                shift <= {shift[6:0], 1'b1};
        end
    end

endmodule

// File: tb/tb_cpu6502_bus_responder.sv
// Randomised scoreboard bench for cpu6502_bus_responder: a behavioural bus model
// predicts every read response and the vblank/NMI levels.
module tb_cpu6502_bus_responder;

    localparam int FC = 64;
    localparam int VS = 40;
    localparam int VE = 0;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        we;
    logic        re;
    logic [7:0]  rdata;
    logic        rvalid;
    logic [7:0]  buttons;
    logic        NMI;
    logic        vblank;

    always #5 CLK = ~CLK;

    cpu6502_bus_responder #(
        .RAM_AW(11), .FRAME_CYCLES(FC), .VBL_START(VS), .VBL_END(VE)
    ) dut (
        .CLK(CLK), .RESET(RESET), .addr(addr), .wdata(wdata), .we(we), .re(re),
        .rdata(rdata), .rvalid(rvalid), .buttons(buttons), .NMI(NMI), .vblank(vblank)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] expQ[$];

    // Reference model state
    logic [7:0] ramModel [2048];
    int         frameCnt;
    bit         mVblank, mNmiEn, mNmi, mStrobe, lastWasReset;
    logic [7:0] mLast, mLatched;
    int         mIdx;

    function automatic logic joyBit();
        logic [7:0] l;
        l = mLatched;
        return (mIdx < 8) ? l[7 - mIdx] : 1'b1;
    endfunction

    // Advance the model by one clock edge using the inputs currently on the bus.
    task automatic modelEdge();
        bit isRam, isPpu, isStatus, isCtrl, isJoy, rd, setNow, clrNow, oldStrobe, nextNmi;
        logic [7:0] v;
        lastWasReset = RESET;
        if (RESET) begin
            mLast = 8'h00; frameCnt = 0; mVblank = 0; mNmiEn = 0; mNmi = 0;
            mStrobe = 0; mLatched = 8'hFF; mIdx = 0;
            return;
        end
        isRam     = addr < 16'h2000;
        isPpu     = addr >= 16'h2000 && addr < 16'h4000;
        isStatus  = isPpu && (addr % 8 == 2);
        isCtrl    = isPpu && (addr % 8 == 0);
        isJoy     = addr == 16'h4016;
        rd        = re && !we;
        setNow    = frameCnt == VS;
        clrNow    = frameCnt == VE;
        oldStrobe = mStrobe;
        nextNmi   = mVblank && mNmiEn;
        if (rd) begin
            v = mLast;
            if (isRam)         v = ramModel[addr % 2048];
            else if (isStatus) v = (mVblank && !setNow) ? 8'h80 : 8'h00;
            else if (isJoy)    v = {7'b0100000, oldStrobe ? buttons[7] : joyBit()};
            mLast = v;
            expQ.push_back(v);
            if (isJoy && !oldStrobe) mIdx++;
        end
        if (we) begin
            if (isRam)  ramModel[addr % 2048] = wdata;
            if (isCtrl) mNmiEn = wdata[7];
            if (isJoy)  mStrobe = wdata[0];
        end
        if (oldStrobe) begin
            mLatched = buttons;
            mIdx = 0;
        end
        if (setNow)                 mVblank = 1;
        else if (clrNow)            mVblank = 0;
        else if (rd && isStatus)    mVblank = 0;
        frameCnt = (frameCnt + 1) % FC;
        mNmi = nextNmi;
    endtask

    task automatic checkOutput();
        checks++;
        if (vblank !== mVblank) begin
            errors++;
            $display("[TB] FAIL vblank got %b exp %b at %0t", vblank, mVblank, $time);
        end
        checks++;
        if (NMI !== mNmi) begin
            errors++;
            $display("[TB] FAIL NMI got %b exp %b at %0t", NMI, mNmi, $time);
        end
        if (lastWasReset) begin
            checks++;
            if (rvalid !== 1'b0 || rdata !== 8'h00) begin
                errors++;
                $display("[TB] FAIL reset_state got rvalid=%b rdata=%h exp 0/00", rvalid, rdata);
            end
        end
    endtask

    task automatic applyStimulus(input bit r, input logic [15:0] a, input logic [7:0] d,
                                 input bit w, input bit rd);
        @(negedge CLK);
        RESET = r; addr = a; wdata = d; we = w; re = rd;
        @(posedge CLK);
        modelEdge();
        #1 checkOutput();
    endtask

    task automatic idle();
        applyStimulus(0, 16'h0000, 8'h00, 0, 0);
    endtask

    // Monitor: every rvalid pulse must match the oldest predicted response.
    always @(negedge CLK) begin
        if (rvalid === 1'b1) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_rvalid got rdata=%h exp none", rdata);
            end else begin
                logic [7:0] e;
                e = expQ.pop_front();
                if (rdata !== e) begin
                    errors++;
                    $display("[TB] FAIL rdata got %h exp %h at %0t", rdata, e, $time);
                end
            end
        end else if (expQ.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL missing_rvalid got rvalid=%b exp 1", rvalid);
            expQ.delete();
        end
    end

    function automatic logic [15:0] randAddr();
        logic [15:0] a;
        case ($urandom_range(0, 5))
            0: a = 16'($urandom_range(0, 16'h1FFF));
            1: a = 16'h2000 | 16'($urandom_range(0, 16'h1FFF));
            2: a = 16'h2002 | 16'($urandom_range(0, 1023) << 3);
            3: a = 16'h2000 | 16'($urandom_range(0, 1023) << 3);
            4: a = 16'h4016;
            default: begin
                case ($urandom_range(0, 3))
                    0: a = 16'h4017;
                    1: a = 16'h5000;
                    2: a = 16'h8000 | 16'($urandom_range(0, 16'h7FFF));
                    default: a = 16'h4015;
                endcase
            end
        endcase
        return a;
    endfunction

    initial begin
        RESET = 1; addr = 0; wdata = 0; we = 0; re = 0; buttons = 8'h00;
        applyStimulus(1, 16'h0000, 8'h00, 0, 0);
        applyStimulus(1, 16'h0000, 8'h00, 0, 0);

        for (int i = 0; i < 2048; i++)
            applyStimulus(0, 16'(i), 8'($urandom), 1, 0);

        // Mirror and back-to-back reads
        applyStimulus(0, 16'h0005, 8'hA5, 1, 0);
        applyStimulus(0, 16'h0805, 8'h00, 0, 1);
        applyStimulus(0, 16'h3FF8, 8'h00, 0, 1);
        applyStimulus(0, 16'h0000, 8'h00, 0, 1);

        // NMI enable, vblank onset, status read clears
        applyStimulus(0, 16'h2000, 8'h80, 1, 0);
        for (int k = 0; k < 2 * FC && !(mVblank && mNmi); k++) idle();
        applyStimulus(0, 16'h2002, 8'h00, 0, 1);
        idle();
        applyStimulus(0, 16'h2002, 8'h00, 0, 1);

        // Status read exactly on the set cycle
        for (int k = 0; k < 2 * FC && frameCnt != VS; k++) idle();
        applyStimulus(0, 16'h2002, 8'h00, 0, 1);
        idle();

        // Joypad serial read
        buttons = 8'h81;
        applyStimulus(0, 16'h4016, 8'h01, 1, 0);
        applyStimulus(0, 16'h4016, 8'h00, 1, 0);
        for (int k = 0; k < 9; k++) applyStimulus(0, 16'h4016, 8'h00, 0, 1);

        // Open bus after a known value
        applyStimulus(0, 16'h0010, 8'h3C, 1, 0);
        applyStimulus(0, 16'h0010, 8'h00, 0, 1);
        applyStimulus(0, 16'h5000, 8'h00, 0, 1);

        // Reset mid-frame with a read in the reset cycle
        for (int k = 0; k < 2 * FC && frameCnt != VS + 5; k++) idle();
        applyStimulus(1, 16'h0000, 8'h00, 0, 1);
        idle();

        for (int n = 0; n < 4000; n++) begin
            int sel;
            if ($urandom_range(0, 19) == 0) buttons = 8'($urandom);
            sel = $urandom_range(0, 9);
            if ($urandom_range(0, 299) == 0)
                applyStimulus(1, randAddr(), 8'($urandom), 0, 1);
            else if (sel < 4)
                applyStimulus(0, randAddr(), 8'($urandom), 0, 1);
            else if (sel < 6)
                applyStimulus(0, randAddr(), 8'($urandom), 1, 0);
            else if (sel == 6)
                applyStimulus(0, randAddr(), 8'($urandom), 1, 1);
            else
                applyStimulus(0, randAddr(), 8'($urandom), 0, 0);
        end

        idle();
        idle();
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain got %0d pending exp 0", expQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
